// File: rtl/pnr_discriminator_pkg.sv
// Shared types and helpers for the photon-number-resolving discriminator.
// Functions work at MAX_W so any ADC/level width up to 32 can reuse them.
package pnr_pkg;

  localparam int MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    PEAK,
    HOLD
  } state_t;

  // Negation that maps the most negative w-bit value to the most positive one.
  function automatic logic signed [MAX_W-1:0] sat_neg(
    input logic signed [MAX_W-1:0] x,
    input int                      w
  );
    logic signed [MAX_W-1:0] lo;
    lo = -(32'sd1 <<< (w - 1));
    if (x == lo) sat_neg = ~lo;
    else         sat_neg = -x;
  endfunction

  function automatic logic [7:0] popcount(
    input logic [MAX_W-1:0] v
  );
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < MAX_W; i++)
      n = n + 8'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/pnr_discriminator_if.sv
// Per-channel event bundle: strobe, held photon code, overflow flag, counter.
// The channel drives it through master; consumers read it through slave.
interface pnr_discriminator_if #(
  parameter int CODE_W = 3,
  parameter int CNT_W  = 32
);

  logic              valid;
  logic [CODE_W-1:0] code;
  logic              ovf;
  logic [CNT_W-1:0]  cnt;

  modport master (
    output valid,
    output code,
    output ovf,
    output cnt
  );

  modport slave (
    input valid,
    input code,
    input ovf,
    input cnt
  );

endinterface

// File: rtl/pnr_discriminator_channel.sv
// One PNR channel: conditioning stage, pulse FSM, peak tracker,
// threshold-ladder quantiser and event counter.
module pnr_channel
  import pnr_pkg::*;
#(
  parameter int ADC_W  = 14,
  parameter int N_LEV  = 7,
  parameter int CODE_W = 3,
  parameter int WID_W  = 10,
  parameter int CNT_W  = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_en,
  input  logic                   i_invert,
  input  logic [ADC_W-1:0]       i_data,
  input  logic [ADC_W-1:0]       i_thr_trig,
  input  logic [N_LEV*ADC_W-1:0] i_thr_lev,
  input  logic [WID_W-1:0]       i_max_width,
  input  logic [WID_W-1:0]       i_holdoff,
  input  logic                   i_cnt_clr,
  output logic                   o_emit,
  pnr_discriminator_if.master    o_ev
);

  localparam logic signed [ADC_W-1:0] PEAK_MIN =
    {1'b1, {(ADC_W-1){1'b0}}};
  localparam logic [WID_W-1:0] W_ONE = WID_W'(1);
  localparam logic [WID_W:0]   H_ONE = (WID_W+1)'(1);
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  logic signed [ADC_W-1:0] w_x;
  logic signed [ADC_W-1:0] w_s;
  logic signed [ADC_W-1:0] w_thr;
  logic                    w_above;

  logic signed [ADC_W-1:0] r_s;
  logic                    r_above;
  logic                    r_above_d;

  state_t                  r_state;
  state_t                  w_nxt;
  logic                    w_trig;
  logic                    w_exit;
  logic                    w_wlim;
  logic [WID_W:0]          w_hnext;
  logic [MAX_W-1:0]        w_gt;

  logic signed [ADC_W-1:0] r_peak;
  logic [WID_W-1:0]        r_width;
  logic [WID_W-1:0]        r_hcnt;
  logic                    r_emit;
  logic                    r_ovf_p;

  logic                    r_valid;
  logic [CODE_W-1:0]       r_code;
  logic                    r_ovf;
  logic [CNT_W-1:0]        r_cnt;

  assign w_x   = $signed(i_data);
  assign w_thr = $signed(i_thr_trig);
  assign w_s   = i_invert
               ? ADC_W'(sat_neg(MAX_W'(w_x), ADC_W))
               : w_x;
  assign w_above = w_s > w_thr;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s       <= '0;
      r_above   <= 1'b0;
      r_above_d <= 1'b0;
    end else begin
      r_s       <= w_s;
      r_above   <= w_above;
      r_above_d <= r_above;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_nxt;
  end

  assign w_hnext = {1'b0, r_hcnt} + H_ONE;

  always_comb begin
    w_nxt  = r_state;
    w_trig = 1'b0;
    w_exit = 1'b0;
    w_wlim = (i_max_width != '0) &&
             (r_width == i_max_width);
    unique case (r_state)
      IDLE: begin
        if (r_above && !r_above_d) begin
          w_trig = 1'b1;
          w_nxt  = PEAK;
        end
      end
      PEAK: begin
        if (!r_above || w_wlim) begin
          w_exit = 1'b1;
          w_nxt  = (i_holdoff == '0) ? IDLE : HOLD;
        end
      end
      HOLD: begin
        if (w_hnext >= {1'b0, i_holdoff})
          w_nxt = IDLE;
      end
      default: w_nxt = IDLE;
    endcase
    if (!i_en) begin
      w_nxt  = IDLE;
      w_trig = 1'b0;
      w_exit = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_peak  <= PEAK_MIN;
      r_width <= '0;
      r_hcnt  <= '0;
      r_emit  <= 1'b0;
      r_ovf_p <= 1'b0;
    end else begin
      r_emit  <= w_exit;
      // still above threshold at exit means the width limit cut it off
      r_ovf_p <= w_exit && r_above;
      if (w_trig) begin
        r_peak  <= r_s;
        r_width <= W_ONE;
      end else if (r_state == PEAK && !w_exit && i_en) begin
        if (r_s > r_peak) r_peak <= r_s;
        if (r_width != '1) r_width <= r_width + W_ONE;
      end
      if (w_exit)                r_hcnt <= '0;
      else if (r_state == HOLD)  r_hcnt <= w_hnext[WID_W-1:0];
    end
  end

  always_comb begin
    w_gt = '0;
    for (int i = 0; i < N_LEV; i++)
      w_gt[i] = r_peak > $signed(i_thr_lev[i*ADC_W +: ADC_W]);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_code  <= '0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_valid <= r_emit;
      if (r_emit) begin
        r_code <= CODE_W'(popcount(w_gt));
        r_ovf  <= r_ovf_p;
      end
      if (i_cnt_clr)   r_cnt <= '0;
      else if (r_emit) r_cnt <= r_cnt + C_ONE;
    end
  end

  assign o_emit        = r_emit;
  assign o_ev.valid    = r_valid;
  assign o_ev.code     = r_code;
  assign o_ev.ovf      = r_ovf;
  assign o_ev.cnt      = r_cnt;

endmodule

// File: rtl/pnr_discriminator.sv
// Multi-channel PNR discriminator: N_CH independent channels plus a
// coincidence strobe aligned with the per-channel pnr_valid outputs.
module pnr_discriminator
  import pnr_pkg::*;
#(
  parameter int N_CH   = 2,
  parameter int ADC_W  = 14,
  parameter int N_LEV  = 7,
  parameter int CODE_W = 3,
  parameter int WID_W  = 10,
  parameter int CNT_W  = 32
) (
  input  logic                        ADC_CLK,
  input  logic                        ADC_RSTN,
  input  logic [N_CH*ADC_W-1:0]       ADC_DATA,
  input  logic                        en,
  input  logic [N_CH-1:0]             invert,
  input  logic [N_CH*ADC_W-1:0]       thr_trig,
  input  logic [N_CH*N_LEV*ADC_W-1:0] thr_lev,
  input  logic [WID_W-1:0]            max_width,
  input  logic [WID_W-1:0]            holdoff,
  input  logic                        cnt_clr,
  output logic [N_CH-1:0]             pnr_valid,
  output logic [N_CH*CODE_W-1:0]      pnr_code,
  output logic [N_CH-1:0]             pnr_ovf,
  output logic                        coinc,
  output logic [N_CH*CNT_W-1:0]       evt_cnt
);

  logic [N_CH-1:0] w_emit;
  logic            r_coinc;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    pnr_discriminator_if #(
      .CODE_W (CODE_W),
      .CNT_W  (CNT_W)
    ) u_if ();

    pnr_channel #(
      .ADC_W  (ADC_W),
      .N_LEV  (N_LEV),
      .CODE_W (CODE_W),
      .WID_W  (WID_W),
      .CNT_W  (CNT_W)
    ) u_ch (
      .i_clk       (ADC_CLK),
      .i_rst_n     (ADC_RSTN),
      .i_en        (en),
      .i_invert    (invert[c]),
      .i_data      (ADC_DATA[c*ADC_W +: ADC_W]),
      .i_thr_trig  (thr_trig[c*ADC_W +: ADC_W]),
      .i_thr_lev   (thr_lev[c*N_LEV*ADC_W +: N_LEV*ADC_W]),
      .i_max_width (max_width),
      .i_holdoff   (holdoff),
      .i_cnt_clr   (cnt_clr),
      .o_emit      (w_emit[c]),
      .o_ev        (u_if)
    );

    assign pnr_valid[c]                 = u_if.valid;
    assign pnr_code[c*CODE_W +: CODE_W] = u_if.code;
    assign pnr_ovf[c]                   = u_if.ovf;
    assign evt_cnt[c*CNT_W +: CNT_W]    = u_if.cnt;
  end

  // built from the pre-strobe emit flags so it lands with pnr_valid
  always_ff @(posedge ADC_CLK) begin
    if (!ADC_RSTN) r_coinc <= 1'b0;
    else           r_coinc <= &w_emit;
  end

  assign coinc = r_coinc;

endmodule

// File: tb/tb_pnr_discriminator.sv
// Scoreboard bench for pnr_discriminator: directed pulses push expected
// strobes (cycle, codes, flags, counters); a negedge monitor checks them.
module tb_pnr_discriminator;

  localparam int N_CH   = 2;
  localparam int ADC_W  = 14;
  localparam int N_LEV  = 7;
  localparam int CODE_W = 3;
  localparam int WID_W  = 10;
  localparam int CNT_W  = 32;

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic [N_CH*ADC_W-1:0]       adc_data;
  logic                        en;
  logic [N_CH-1:0]             invert;
  logic [N_CH*ADC_W-1:0]       thr_trig;
  logic [N_CH*N_LEV*ADC_W-1:0] thr_lev;
  logic [WID_W-1:0]            max_width;
  logic [WID_W-1:0]            holdoff;
  logic                        cnt_clr;
  logic [N_CH-1:0]             pnr_valid;
  logic [N_CH*CODE_W-1:0]      pnr_code;
  logic [N_CH-1:0]             pnr_ovf;
  logic                        coinc;
  logic [N_CH*CNT_W-1:0]       evt_cnt;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  pnr_discriminator #(
    .N_CH (N_CH), .ADC_W (ADC_W), .N_LEV (N_LEV),
    .CODE_W (CODE_W), .WID_W (WID_W), .CNT_W (CNT_W)
  ) dut (
    .ADC_CLK   (clk),
    .ADC_RSTN  (rst_n),
    .ADC_DATA  (adc_data),
    .en        (en),
    .invert    (invert),
    .thr_trig  (thr_trig),
    .thr_lev   (thr_lev),
    .max_width (max_width),
    .holdoff   (holdoff),
    .cnt_clr   (cnt_clr),
    .pnr_valid (pnr_valid),
    .pnr_code  (pnr_code),
    .pnr_ovf   (pnr_ovf),
    .coinc     (coinc),
    .evt_cnt   (evt_cnt)
  );

  pnr_discriminator_if #(.CODE_W(CODE_W), .CNT_W(CNT_W)) u_mon0 ();
  pnr_discriminator_if #(.CODE_W(CODE_W), .CNT_W(CNT_W)) u_mon1 ();

  assign u_mon0.valid = pnr_valid[0];
  assign u_mon0.code  = pnr_code[2:0];
  assign u_mon0.ovf   = pnr_ovf[0];
  assign u_mon0.cnt   = evt_cnt[31:0];
  assign u_mon1.valid = pnr_valid[1];
  assign u_mon1.code  = pnr_code[5:3];
  assign u_mon1.ovf   = pnr_ovf[1];
  assign u_mon1.cnt   = evt_cnt[63:32];

  typedef struct {
    int          t;
    logic [1:0]  v;
    logic        c;
    logic [2:0]  code0;
    logic [2:0]  code1;
    logic        ovf0;
    logic        ovf1;
    logic [31:0] cnt0;
    logic [31:0] cnt1;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [2:0]  m_code[2];
  logic        m_ovf[2];
  logic [31:0] m_cnt[2];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int t, input logic [1:0] v,
                      input logic [2:0] c0, input logic [2:0] c1,
                      input logic o0, input logic o1,
                      input logic clr);
    exp_t e;
    if (v[0]) begin m_code[0] = c0; m_ovf[0] = o0; end
    if (v[1]) begin m_code[1] = c1; m_ovf[1] = o1; end
    if (clr) begin
      m_cnt[0] = 0;
      m_cnt[1] = 0;
    end else begin
      if (v[0]) m_cnt[0] = m_cnt[0] + 1;
      if (v[1]) m_cnt[1] = m_cnt[1] + 1;
    end
    e.t = t;  e.v = v;  e.c = &v;
    e.code0 = m_code[0];  e.code1 = m_code[1];
    e.ovf0 = m_ovf[0];    e.ovf1 = m_ovf[1];
    e.cnt0 = m_cnt[0];    e.cnt1 = m_cnt[1];
    q.push_back(e);
  endtask

  task automatic drv(input int a0, input int a1);
    @(negedge clk);
    adc_data = {14'(a1), 14'(a0)};
  endtask

  task automatic idle(input int n);
    repeat (n) drv(0, 0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_valid"}, pnr_valid, 0);
    chk({nm, "_code"}, pnr_code, 0);
    chk({nm, "_ovf"}, pnr_ovf, 0);
    chk({nm, "_coinc"}, coinc, 0);
    chk({nm, "_cnt"}, evt_cnt, 0);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if ((u_mon0.valid | u_mon1.valid | coinc) === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_strobe", q.size(), 1);
      end else begin
        e = q.pop_front();
        chk("strobe_cycle", cyc, e.t);
        chk("valid", {u_mon1.valid, u_mon0.valid}, e.v);
        chk("coinc", coinc, e.c);
        chk("code0", u_mon0.code, e.code0);
        chk("code1", u_mon1.code, e.code1);
        chk("ovf0", u_mon0.ovf, e.ovf0);
        chk("ovf1", u_mon1.ovf, e.ovf1);
        chk("cnt0", u_mon0.cnt, e.cnt0);
        chk("cnt1", u_mon1.cnt, e.cnt1);
      end
    end
  end

  int amps[4] = '{150, 1400, 1401, 200};
  int lv[4]   = '{0, 6, 7, 0};

  initial begin
    adc_data  = '0;
    en        = 1'b1;
    invert    = '0;
    max_width = '0;
    holdoff   = '0;
    cnt_clr   = 1'b0;
    thr_trig  = {14'd100, 14'd100};
    for (int c = 0; c < N_CH; c++)
      for (int i = 0; i < N_LEV; i++)
        thr_lev[(c*N_LEV+i)*ADC_W +: ADC_W] = 14'((i + 1) * 200);
    for (int c = 0; c < 2; c++) begin
      m_code[c] = '0; m_ovf[c] = 1'b0; m_cnt[c] = '0;
    end

    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    idle(3);

    drv(0, 0); drv(250, 0); drv(500, 0); drv(250, 0); drv(0, 0);
    push(cyc + 3, 2'b01, 3'd2, 3'd0, 1'b0, 1'b0, 1'b0);
    idle(6);

    for (int k = 0; k < 4; k++) begin
      drv(amps[k], 0); drv(amps[k], 0); drv(0, 0);
      push(cyc + 3, 2'b01, 3'(lv[k]), 3'd0, 1'b0, 1'b0, 1'b0);
      idle(4);
    end

    drv(100, 0); drv(100, 0); drv(100, 0);
    idle(4);

    invert = 2'b10;
    idle(2);
    drv(0, -8192); drv(0, -8192); drv(0, -8192); drv(0, 0);
    push(cyc + 3, 2'b10, 3'd0, 3'd7, 1'b0, 1'b0, 1'b0);
    idle(4);
    drv(0, -700); drv(0, -700); drv(0, 0);
    push(cyc + 3, 2'b10, 3'd0, 3'd3, 1'b0, 1'b0, 1'b0);
    idle(4);
    invert = 2'b00;

    max_width = 10'd8;
    idle(2);
    drv(1000, 0);
    push(cyc + 11, 2'b01, 3'd4, 3'd0, 1'b1, 1'b0, 1'b0);
    repeat (39) drv(1000, 0);
    drv(0, 0);
    idle(2);
    drv(1000, 0); drv(1000, 0); drv(0, 0);
    push(cyc + 3, 2'b01, 3'd4, 3'd0, 1'b0, 1'b0, 1'b0);
    idle(4);
    max_width = '0;

    holdoff = 10'd20;
    drv(300, 0); drv(300, 0); drv(300, 0); drv(0, 0);
    push(cyc + 3, 2'b01, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0);
    idle(6);
    drv(300, 0); drv(300, 0); drv(300, 0); drv(0, 0);
    idle(30);
    drv(300, 0); drv(300, 0); drv(300, 0); drv(0, 0);
    push(cyc + 3, 2'b01, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0);
    idle(26);
    drv(900, 0); drv(900, 0); drv(900, 0); drv(0, 0);
    push(cyc + 3, 2'b01, 3'd4, 3'd0, 1'b0, 1'b0, 1'b0);
    idle(30);
    holdoff = '0;

    drv(450, 450); drv(450, 450); drv(450, 450); drv(0, 0);
    push(cyc + 3, 2'b11, 3'd2, 3'd2, 1'b0, 1'b0, 1'b0);
    idle(4);
    drv(450, 0); drv(450, 450); drv(450, 450); drv(0, 450);
    push(cyc + 3, 2'b01, 3'd2, 3'd0, 1'b0, 1'b0, 1'b0);
    drv(0, 0);
    push(cyc + 3, 2'b10, 3'd0, 3'd2, 1'b0, 1'b0, 1'b0);
    idle(4);

    drv(500, 500); drv(500, 500); drv(500, 500);
    @(negedge clk);
    rst_n = 1'b0;
    adc_data = '0;
    @(negedge clk);
    chk_zero("midpulse_reset");
    for (int c = 0; c < 2; c++) begin
      m_code[c] = '0; m_ovf[c] = 1'b0; m_cnt[c] = '0;
    end
    rst_n = 1'b1;
    idle(6);

    drv(800, 0); drv(800, 0); drv(0, 0);
    push(cyc + 3, 2'b01, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0);
    idle(4);
    drv(600, 0); drv(600, 0); drv(600, 0);
    en = 1'b0;
    drv(600, 0); drv(0, 0);
    idle(4);
    en = 1'b1;
    idle(2);
    chk("en_hold_code", pnr_code[2:0], m_code[0]);
    chk("en_hold_cnt", evt_cnt[31:0], m_cnt[0]);

    drv(0, 450); drv(0, 450); drv(0, 0);
    push(cyc + 3, 2'b10, 3'd0, 3'd2, 1'b0, 1'b0, 1'b1);
    cnt_clr = 1'b1;
    idle(4);
    cnt_clr = 1'b0;
    idle(2);
    drv(250, 0); drv(250, 0); drv(0, 0);
    push(cyc + 3, 2'b01, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0);
    idle(8);

    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
